hid_rx_decoder: RTL and testbench

Parametrised PS/2 (HID) keyboard receiver that replaces the single-register LED-latch receiver. It provides:
- glitch-filtered clock and data, and full frame checking (start, odd parity, stop);
- scan-code prefix decoding (E0 extended, F0 break);
- a FIFO of key events with a valid/ready handshake.

It sits between the PS/2 pins and any consumer, such as the LED/display logic or a soft CPU.

---
 rtl/hid_pkg.sv | 23 ++
 rtl/hid_rx_decoder_if.sv | 13 +
 rtl/hid_evt_fifo.sv | 58 +++++
 rtl/hid_rx_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_hid_rx_decoder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hid_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package hid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PARI = 2'd2,
        ST_STOP = 2'd3
    } hid_state_e;

    localparam logic [7:0] HID_PFX_EXT = 8'hE0;
    localparam logic [7:0] HID_PFX_BRK = 8'hF0;

    localparam int HID_EVT_W = 10;

    // Key event as stored in the FIFO: {ext, break, code}
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } hid_evt_t;

endpackage

// File: rtl/hid_rx_decoder_if.sv
// Key-event stream: valid/ready handshake with the decoded scan code.
interface hid_rx_decoder_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (output evt_valid, output evt_code, output evt_ext,
                    output evt_break, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_ext,
                    input evt_break, output evt_ready);
endinterface

// File: rtl/hid_evt_fifo.sv
// Synchronous show-ahead FIFO; dout shows the head entry, zero when empty.
// A push while full is accepted only if a pop happens in the same cycle.
module hid_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     dspclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];
    assign level   = level_q;

    // storage array, written on accepted pushes only
    always_ff @(posedge dspclk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge dspclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/hid_rx_decoder.sv
// PS/2 keyboard receiver: pin synchronisers, clock glitch filter, frame FSM,
// E0/F0 prefix decoder and key-event FIFO.
// Optional build macro PS2_WDOG_EN adds a watchdog that aborts stalled frames.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for a falling edge with start bit 0
// DATA    | shifting in 8 data bits, LSB first
// PARI    | capturing the parity bit
// STOP    | sampling the stop bit and checking the frame
module hid_rx_decoder
    import hid_pkg::*;
#(
    parameter int FILT_LEN   = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic                          dspclk,
    input  logic                          reset,
    input  logic                          hid_clk,
    input  logic                          hid_dat,
    hid_rx_decoder_if.master              evt,
    output logic                          pari_err,
    output logic                          frm_err,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int FCW = $clog2(FILT_LEN);

    logic           clk_s1_q, clk_s2_q;
    logic           dat_s1_q, dat_s2_q;
    logic           filt_clk_q, filt_prev_q;
    logic [FCW-1:0] fcnt_q;
    logic           fall;

    hid_state_e     state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic           frame_done;
    logic           good_q, good_d;
    logic           pari_err_q, pari_err_d;
    logic           frm_err_q, frm_err_d;
    logic           wd_abort;

    logic           ext_q, ext_d;
    logic           brk_q, brk_d;
    logic           push_req;
    hid_evt_t       push_evt;
    hid_evt_t       head_evt;
    logic           fifo_empty, fifo_full;
    logic           evt_pop;

    // two-flop synchronisers, idle-high reset value
    always_ff @(posedge dspclk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= hid_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= hid_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // clock filter: toggle only after FILT_LEN consecutive differing samples
    always_ff @(posedge dspclk or posedge reset) begin
        if (reset) begin
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            filt_prev_q <= filt_clk_q;
            if (clk_s2_q != filt_clk_q) begin
                if (fcnt_q == FCW'(FILT_LEN - 1)) begin
                    filt_clk_q <= clk_s2_q;
                    fcnt_q     <= '0;
                end else begin
                    fcnt_q <= fcnt_q + FCW'(1);
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_clk_q;

`ifdef PS2_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt_q;
    logic           filt_edge;

    assign filt_edge = filt_prev_q ^ filt_clk_q;
    assign wd_abort  = (state_q != ST_IDLE) && (wd_cnt_q == WDW'(TIMEOUT));

    // watchdog: restarts on every filtered edge, saturates at TIMEOUT
    always_ff @(posedge dspclk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) || filt_edge) begin
            wd_cnt_q <= '0;
        end else if (wd_cnt_q != WDW'(TIMEOUT)) begin
            wd_cnt_q <= wd_cnt_q + WDW'(1);
        end
    end
`else
    assign wd_abort = 1'b0;
`endif

    // frame FSM state and check-result registers
    always_ff @(posedge dspclk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            good_q     <= 1'b0;
            pari_err_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            good_q     <= good_d;
            pari_err_q <= pari_err_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // frame FSM next state; the stop fall produces the frame verdict
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        frame_done = 1'b0;
        if (wd_abort) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = ST_PARI;
                end
                ST_PARI: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // a bad stop bit wins over bad parity
        good_d     = frame_done & dat_s2_q & (^{shift_q, par_q});
        pari_err_d = frame_done & dat_s2_q & ~(^{shift_q, par_q});
        frm_err_d  = (frame_done & ~dat_s2_q) | wd_abort;
    end

    assign pari_err = pari_err_q;
    assign frm_err  = frm_err_q;

    // prefix flags: shift_q still holds the finished byte while good_q is high
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        push_req = 1'b0;
        if (pari_err_q || frm_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (good_q) begin
            if (shift_q == HID_PFX_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == HID_PFX_BRK) begin
                brk_d = 1'b1;
            end else begin
                push_req = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end
    end

    // prefix flag registers
    always_ff @(posedge dspclk or posedge reset) begin
        if (reset) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end

    assign push_evt = '{ext: ext_q, brk: brk_q, code: shift_q};
    assign evt_pop  = evt.evt_valid & evt.evt_ready;
    assign ovf      = push_req & fifo_full & ~evt_pop;

    hid_evt_fifo #(
        .WIDTH (HID_EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .dspclk (dspclk),
        .reset  (reset),
        .push   (push_req),
        .pop    (evt_pop),
        .din    (push_evt),
        .dout   (head_evt),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (fifo_level)
    );

    assign evt.evt_valid = ~fifo_empty;
    assign evt.evt_code  = head_evt.code;
    assign evt.evt_ext   = head_evt.ext;
    assign evt.evt_break = head_evt.brk;

endmodule

// File: tb/tb_hid_rx_decoder.sv
// Self-checking bench for hid_rx_decoder with an event scoreboard.
module tb_hid_rx_decoder;
    import hid_pkg::*;

    localparam int FILT_LEN   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 2000;

    logic       dspclk = 1'b0;
    logic       reset;
    logic       hid_clk;
    logic       hid_dat;
    logic       pari_err, frm_err, ovf;
    logic [2:0] fifo_level;

    hid_rx_decoder_if evt_if ();

    hid_rx_decoder #(
        .FILT_LEN   (FILT_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .dspclk     (dspclk),
        .reset      (reset),
        .hid_clk    (hid_clk),
        .hid_dat    (hid_dat),
        .evt        (evt_if),
        .pari_err   (pari_err),
        .frm_err    (frm_err),
        .ovf        (ovf),
        .fifo_level (fifo_level)
    );

    always #5 dspclk = ~dspclk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [9:0] sb_q [$];
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;

    int pari_cnt = 0, frm_cnt = 0, ovf_cnt = 0, valid_cycles = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // monitor: count pulses and compare each handshaken event with the scoreboard
    always @(negedge dspclk) begin
        if (reset === 1'b0) begin
            if (pari_err) pari_cnt++;
            if (frm_err)  frm_cnt++;
            if (ovf)      ovf_cnt++;
            if (evt_if.evt_valid) begin
                valid_cycles++;
                if (evt_if.evt_ready) begin
                    if (sb_q.size() == 0)
                        check_eq("spurious_evt", evt_if.evt_valid, 0);
                    else
                        check_eq("evt", {evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code},
                                 sb_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge dspclk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        hid_dat = b;
        cyc(100);
        hid_clk = 1'b0;
        cyc(200);
        hid_clk = 1'b1;
        cyc(100);
    endtask

    // nbits < 11 sends a truncated frame and leaves the model untouched
    task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nbits = 11);
        logic [10:0] fr;
        fr = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        if (nbits == 11) begin
            if (bad_par) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (code == 8'hE0) begin
                m_ext = 1'b1;
            end else if (code == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                if (!(evt_if.evt_ready == 1'b0 && sb_q.size() >= FIFO_DEPTH))
                    sb_q.push_back({m_ext, m_brk, code});
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        hid_dat = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            cyc(1);
            n++;
        end
        check_eq("drain", sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int p0, f0, o0, v0, n;

        reset            = 1'b1;
        hid_clk          = 1'b1;
        hid_dat          = 1'b1;
        evt_if.evt_ready = 1'b0;
        cyc(5);
        reset = 1'b0;
        cyc(5);
        check_eq("rst_valid", evt_if.evt_valid, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_code",  evt_if.evt_code, 0);
        check_eq("rst_pulses", {pari_err, frm_err, ovf}, 0);

        // single clean frame
        evt_if.evt_ready = 1'b1;
        p0 = pari_cnt; f0 = frm_cnt; v0 = valid_cycles;
        send_frame(8'h1C, 0);
        cyc(20);
        wait_drain();
        check_eq("1c_valid_cycles", valid_cycles - v0, 1);
        check_eq("1c_pari", pari_cnt - p0, 0);
        check_eq("1c_frm",  frm_cnt - f0, 0);

        // extended break code
        v0 = valid_cycles;
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        cyc(20);
        wait_drain();
        check_eq("e0f075_events", valid_cycles - v0, 1);

        // bad parity then clean frame
        p0 = pari_cnt; f0 = frm_cnt; v0 = valid_cycles;
        send_frame(8'h1C, 1);
        cyc(20);
        check_eq("badpar_pari", pari_cnt - p0, 1);
        check_eq("badpar_frm",  frm_cnt - f0, 0);
        check_eq("badpar_noevt", valid_cycles - v0, 0);
        p0 = pari_cnt;
        send_frame(8'h1C, 0);
        cyc(20);
        wait_drain();
        check_eq("after_badpar_pari", pari_cnt - p0, 0);

        // short clock glitches with data low must not start a frame
        p0 = pari_cnt; f0 = frm_cnt; v0 = valid_cycles;
        hid_dat = 1'b0;
        for (int i = 0; i < 10; i++) begin
            hid_clk = 1'b0;
            cyc(3);
            hid_clk = 1'b1;
            cyc(20);
        end
        hid_dat = 1'b1;
        cyc(50);
        check_eq("glitch_noevt", valid_cycles - v0, 0);
        check_eq("glitch_err", (pari_cnt - p0) + (frm_cnt - f0), 0);

        // overflow: five events into a four-entry FIFO
        evt_if.evt_ready = 1'b0;
        o0 = ovf_cnt; p0 = pari_cnt; f0 = frm_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
        cyc(20);
        check_eq("ovf_level", fifo_level, 4);
        check_eq("ovf_pulses", ovf_cnt - o0, 1);
        check_eq("ovf_head", evt_if.evt_code, 8'h01);
        check_eq("ovf_err", (pari_cnt - p0) + (frm_cnt - f0), 0);
        evt_if.evt_ready = 1'b1;
        cyc(2);
        wait_drain();
        cyc(2);
        check_eq("ovf_level_empty", fifo_level, 0);

        // truncated frame
        f0 = frm_cnt;
        send_frame(8'h55, 0, 5);
`ifdef PS2_WDOG_EN
        n = 0;
        while (frm_cnt == f0 && n < 4000) begin
            cyc(1);
            n++;
        end
        check_eq("wdog_frm", frm_cnt - f0, 1);
        check_eq("wdog_delay_ok", (n >= 1800 && n <= 2200), 1);
        send_frame(8'h33, 0);
        cyc(20);
        wait_drain();
`else
        n = 0;
        cyc(3000);
        check_eq("nowdog_frm", frm_cnt - f0, 0);
        check_eq("nowdog_valid", evt_if.evt_valid, 0);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(5);
`endif

        // reset mid-frame with events queued
        evt_if.evt_ready = 1'b0;
        send_frame(8'h11, 0);
        send_frame(8'h12, 0);
        cyc(20);
        check_eq("pre_rst_level", fifo_level, 2);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b1;
        sb_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        cyc(3);
        check_eq("midrst_valid", evt_if.evt_valid, 0);
        check_eq("midrst_level", fifo_level, 0);
        hid_dat = 1'b1;
        reset   = 1'b0;
        cyc(5);
        check_eq("postrst_level", fifo_level, 0);
        evt_if.evt_ready = 1'b1;
        v0 = valid_cycles;
        send_frame(8'h29, 0);
        cyc(20);
        wait_drain();
        check_eq("postrst_events", valid_cycles - v0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
